// File: rtl/ring_freq_meter.sv
// Multi-channel ring-oscillator frequency meter with a Wishbone CSR slave.
// Each lane synchronises its divided ring output, counts rising edges over a window and latches the result.

module ring_freq_lane #(
    parameter int CNT_WIDTH   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ring_div,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 latch,
    input  logic                 keep,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf_live,
    output logic                 ovf
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   cnt;

    assign rise = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            hist     <= 1'b0;
            cnt      <= '0;
            ovf_live <= 1'b0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ring_div};
            hist <= sync[SYNC_STAGES-1];
            if (clr) begin
                cnt      <= '0;
                ovf_live <= 1'b0;
            end else if (en && rise) begin
                // saturate; an edge arriving at all-ones flags overflow
                if (&cnt) ovf_live <= 1'b1;
                else      cnt      <= cnt + 1'b1;
            end
            if (latch) begin
                count <= keep ? cnt : '0;
                ovf   <= keep & ovf_live;
            end
        end
    end
endmodule

module ring_freq_meter #(
    parameter int NUM_RINGS   = 4,
    parameter int CNT_WIDTH   = 24,
    parameter int WIN_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic [NUM_RINGS-1:0] ring_div_i,
    output logic [NUM_RINGS-1:0] ring_start_o,
    output logic                 irq_o
);
    localparam int TW = (WIN_WIDTH > 8) ? WIN_WIDTH : 8;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, LATCH} state_t;
    state_t state, state_n;

    logic [NUM_RINGS-1:0]                mask, lane_en, lane_ovf_live, lane_ovf;
    logic [NUM_RINGS-1:0][CNT_WIDTH-1:0] lane_count;
    logic                 cont, irq_en, done, ovf_any, busy;
    logic [WIN_WIDTH-1:0] window, win_sh;
    logic [7:0]           settle;
    logic [TW-1:0]        timer;
    logic [31:0]          rdata;
    logic                 req, wr, ctrl_wr, stat_wr, go_wr, abort_wr;
    logic                 enter_meas, latch;
    logic                 unused;

    assign unused   = ^{wbs_adr_i[31:8], wbs_dat_i};
    assign req      = wbs_stb_i & wbs_cyc_i;
    assign wr       = req & wbs_we_i & (|wbs_sel_i) & wbs_ack_o;
    assign ctrl_wr  = wr & (wbs_adr_i[7:0] == 8'h00);
    assign stat_wr  = wr & (wbs_adr_i[7:0] == 8'h04);
    assign go_wr    = ctrl_wr & wbs_dat_i[0];
    assign abort_wr = ctrl_wr & wbs_dat_i[3];

    assign busy         = (state != IDLE);
    assign ring_start_o = mask & {NUM_RINGS{busy}};
    assign irq_o        = done & irq_en;
    assign lane_en      = mask & {NUM_RINGS{state == MEASURE}};

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_comb begin
        state_n    = state;
        enter_meas = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE:    if (go_wr && |wbs_dat_i[8 +: NUM_RINGS]) state_n = SETTLE;
            SETTLE:  if (timer == '0) begin state_n = MEASURE; enter_meas = 1'b1; end
            MEASURE: if (timer == '0) state_n = LATCH;
            LATCH: begin
                latch = 1'b1;
                if (cont) begin state_n = MEASURE; enter_meas = 1'b1; end
                else      state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort_wr) begin
            state_n    = IDLE;
            enter_meas = 1'b0;
            latch      = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state  <= IDLE;
            timer  <= '0;
            win_sh <= '1;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == SETTLE) begin
                timer  <= dec(TW'(settle));
                win_sh <= window;
            end else if (enter_meas) begin
                // continuous restarts re-read WINDOW; a fresh run uses the go-time shadow
                timer <= dec(state == LATCH ? TW'(window) : TW'(win_sh));
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mask    <= '0;
            cont    <= 1'b0;
            irq_en  <= 1'b0;
            window  <= '1;
            settle  <= 8'hFF;
            done    <= 1'b0;
            ovf_any <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                mask   <= wbs_dat_i[8 +: NUM_RINGS];
                cont   <= wbs_dat_i[1];
                irq_en <= wbs_dat_i[2];
            end
            if (wr && wbs_adr_i[7:0] == 8'h08) window <= wbs_dat_i[WIN_WIDTH-1:0];
            if (wr && wbs_adr_i[7:0] == 8'h0C) settle <= wbs_dat_i[7:0];
            // a LATCH set beats a same-cycle W1C
            done    <= (done & ~(stat_wr & wbs_dat_i[1])) | latch;
            ovf_any <= (ovf_any & ~(stat_wr & wbs_dat_i[2])) | (latch & |(lane_ovf_live & mask));
        end
    end

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[7:0])
            8'h00: begin
                rdata[1]              = cont;
                rdata[2]              = irq_en;
                rdata[8 +: NUM_RINGS] = mask;
            end
            8'h04:   rdata[2:0] = {ovf_any, done, busy};
            8'h08:   rdata[WIN_WIDTH-1:0] = window;
            8'h0C:   rdata[7:0] = settle;
            default: ;
        endcase
        for (int i = 0; i < NUM_RINGS; i++) begin
            if (wbs_adr_i[7:0] == 8'(16 + 4 * i)) begin
                rdata[31]            = lane_ovf[i];
                rdata[CNT_WIDTH-1:0] = lane_count[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req & ~wbs_ack_o;
            wbs_dat_o <= (req & ~wbs_ack_o) ? rdata : '0;
        end
    end

    for (genvar g = 0; g < NUM_RINGS; g++) begin : g_lane
        ring_freq_lane #(.CNT_WIDTH(CNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk      (wb_clk_i),
            .rst_n    (wb_rst_ni),
            .ring_div (ring_div_i[g]),
            .clr      (enter_meas),
            .en       (lane_en[g]),
            .latch    (latch),
            .keep     (mask[g]),
            .count    (lane_count[g]),
            .ovf_live (lane_ovf_live[g]),
            .ovf      (lane_ovf[g])
        );
    end
endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter: stimulus queues expected read data, a negedge monitor compares.
// Expected counts come from window/period arithmetic; expected timing from the documented go-to-done sequence.

module tb_ring_freq_meter;
    localparam int NR = 4;
    localparam int CW = 10;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_w = '0, dat_r;
    logic        ack, irq;
    logic [NR-1:0] ring_div = '0, ring_start;

    ring_freq_meter #(.NUM_RINGS(NR), .CNT_WIDTH(CW), .WIN_WIDTH(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .ring_div_i(ring_div), .ring_start_o(ring_start), .irq_o(irq)
    );

    initial forever #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ring models: half period in ns, phase offset keeps toggles off the clock edges
    int half_ns[NR];
    int acc[NR];
    initial begin
        for (int i = 0; i < NR; i++) begin half_ns[i] = 0; acc[i] = 0; end
        #2;
        forever begin
            #1;
            for (int i = 0; i < NR; i++) begin
                if (half_ns[i] != 0) begin
                    acc[i]++;
                    if (acc[i] >= half_ns[i]) begin
                        acc[i] = 0;
                        ring_div[i] = ~ring_div[i];
                    end
                end
            end
        end
    end

    typedef struct { string name; logic [31:0] exp; logic [31:0] msk; int tol; } rd_t;
    typedef struct { string name; longint act; longint exp; int tol; } dc_t;
    rd_t rd_q[$];
    dc_t dc_q[$];
    int  n_vec = 0, n_err = 0;

    function automatic void compare(string name, longint act, longint exp, int tol);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        n_vec++;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", name, act, exp, tol);
        end
    endfunction

    always @(negedge clk) begin
        dc_t d;
        rd_t r;
        while (dc_q.size() > 0) begin
            d = dc_q.pop_front();
            compare(d.name, d.act, d.exp, d.tol);
        end
        if (ack && !we) begin
            if (rd_q.size() == 0) compare("unexpected_read_ack", 1, 0, 0);
            else begin
                r = rd_q.pop_front();
                compare(r.name, longint'(dat_r & r.msk), longint'(r.exp & r.msk), r.tol);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string n, input longint a, input longint e, input int tol = 0);
        dc_t d;
        d.name = n; d.act = a; d.exp = e; d.tol = tol;
        dc_q.push_back(d);
    endtask

    task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d, output int ackc);
        adr = {24'h0, a}; we = w; dat_w = d; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        ackc = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack) begin ackc = cyc_cnt; break; end
        end
        if (ackc < 0) check("ack_timeout", 0, 1);
        tick();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int c;
        bus(a, 1'b1, d, c);
    endtask

    task automatic rd(input logic [7:0] a, input string n, input logic [31:0] e,
                      input logic [31:0] m = 32'hFFFF_FFFF, input int tol = 0);
        rd_t r;
        int c;
        r.name = n; r.exp = e; r.msk = m; r.tol = tol;
        rd_q.push_back(r);
        bus(a, 1'b0, 32'h0, c);
    endtask

    task automatic wait_irq(input string n, input int budget, output int rc);
        rc = -1;
        for (int i = 0; i < budget; i++) begin
            if (irq) begin rc = cyc_cnt; break; end
            tick();
        end
        if (rc < 0) check(n, 0, 1);
    endtask

    localparam logic [31:0] CMSK = 32'h8000_0000 | ((32'h1 << CW) - 1);

    initial begin
        int t, r, r2, w, s, m;
        int p[NR];

        // reset state
        repeat (3) tick();
        check("rst_ack", ack, 0);
        check("rst_dat", dat_r, 0);
        check("rst_ring_start", ring_start, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;
        tick();
        rd(8'h00, "rst_ctrl", 0);
        rd(8'h04, "rst_status", 0);
        rd(8'h08, "rst_window", 32'hFFFF);
        rd(8'h0C, "rst_settle", 32'hFF);
        for (int i = 0; i < NR; i++) rd(8'(16 + 4 * i), $sformatf("rst_count%0d", i), 0);
        rd(8'h40, "unmapped_read", 0);

        // single ring, period 10 clocks, settle 4, window 1000
        half_ns[0] = 50;
        wr(8'h0C, 4);
        wr(8'h08, 1000);
        bus(8'h00, 1'b1, 32'h0105, t);
        check("settle_ring_start", ring_start, 1);
        wait_irq("irq_timeout_single", 1100, r);
        check("single_done_cycle", r, t + 2 + 4 + 1000);
        check("single_ring_start_off", ring_start, 0);
        rd(8'h10, "single_count0", 100, CMSK, 1);
        rd(8'h04, "single_status", 32'h2);
        wr(8'h04, 32'h2);

        // randomized multi-ring runs
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NR; i++) begin
                p[i] = $urandom_range(6, 24);
                half_ns[i] = 5 * p[i];
            end
            w = $urandom_range(1500, 2400);
            s = $urandom_range(0, 20);
            m = $urandom_range(1, 15);
            wr(8'h0C, s);
            wr(8'h08, w);
            bus(8'h00, 1'b1, 32'h5 | (m << 8), t);
            wait_irq("irq_timeout_rand", w + s + 30, r);
            check("rand_done_cycle", r, t + 2 + ((s == 0) ? 1 : s) + w);
            for (int i = 0; i < NR; i++) begin
                if (m[i]) rd(8'(16 + 4 * i), $sformatf("rand_count%0d", i), w / p[i], CMSK, 1);
                else      rd(8'(16 + 4 * i), $sformatf("rand_off%0d", i), 0);
            end
            wr(8'h04, 32'h2);
        end

        // saturation and overflow
        for (int i = 1; i < NR; i++) half_ns[i] = 0;
        half_ns[0] = 25;
        wr(8'h0C, 4);
        wr(8'h08, 8000);
        bus(8'h00, 1'b1, 32'h0105, t);
        wait_irq("irq_timeout_ovf", 8100, r);
        rd(8'h10, "ovf_count0", 32'h8000_0000 | ((32'h1 << CW) - 1));
        rd(8'h04, "ovf_status", 32'h6);
        wr(8'h04, 32'h4);
        rd(8'h04, "ovf_w1c", 32'h2);
        wr(8'h04, 32'h2);

        // continuous mode, period W+1, W1C on LATCH loses to set, then abort
        half_ns[0] = 50;
        wr(8'h08, 100);
        bus(8'h00, 1'b1, 32'h0107, t);
        wait_irq("irq_timeout_cont1", 200, r);
        wr(8'h04, 32'h2);
        rd(8'h04, "cont_cleared", 32'h1);
        wait_irq("irq_timeout_cont2", 200, r2);
        check("cont_period", r2 - r, 101);
        while (cyc_cnt < r2 + 99) tick();
        bus(8'h04, 1'b1, 32'h2, t);
        check("latch_w1c_ack_cycle", t, r2 + 100);
        rd(8'h04, "latch_w1c_done_kept", 32'h3);
        rd(8'h10, "cont_count0", 10, CMSK, 1);
        wr(8'h00, 32'h0108);
        check("abort_ring_start", ring_start, 0);
        rd(8'h04, "abort_status", 32'h2);
        rd(8'h10, "abort_count_held", 10, CMSK, 1);
        wr(8'h04, 32'h2);

        // go with empty mask
        wr(8'h00, 32'h1);
        tick();
        check("mask0_ring_start", ring_start, 0);
        rd(8'h04, "mask0_status", 0);

        // go while busy and WINDOW written mid-run
        wr(8'h0C, 4);
        wr(8'h08, 200);
        bus(8'h00, 1'b1, 32'h0105, t);
        repeat (20) tick();
        wr(8'h08, 50);
        wr(8'h00, 32'h0105);
        wait_irq("irq_timeout_busy", 300, r);
        check("go_busy_done_cycle", r, t + 2 + 4 + 200);
        wr(8'h04, 32'h2);
        bus(8'h00, 1'b1, 32'h0105, t);
        wait_irq("irq_timeout_next", 100, r);
        check("next_window_done_cycle", r, t + 2 + 4 + 50);
        wr(8'h04, 32'h2);

        // reset during MEASURE
        wr(8'h08, 1000);
        wr(8'h00, 32'h0105);
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ring_start", ring_start, 0);
        check("midrst_irq", irq, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        rd(8'h00, "midrst_ctrl", 0);
        rd(8'h04, "midrst_status", 0);
        rd(8'h08, "midrst_window", 32'hFFFF);
        rd(8'h0C, "midrst_settle", 32'hFF);
        rd(8'h10, "midrst_count0", 0);

        for (int i = 0; i < 50 && (rd_q.size() > 0 || dc_q.size() > 0); i++) tick();
        check("scoreboard_drain", rd_q.size(), 0);
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
